can_tx_arbiter: RTL and testbench
=================================

# can_tx_arbiter

Transmit scheduler sitting between a bank of NUM_FIFOS 128-bit transmit FIFOs (`can_fifo` instances) and the CAN transmit engine. Each time the engine is free, it compares the head frames of all non-empty FIFOs and offers the highest-priority one (lowest arbitration key) over a valid/ready handshake. It then pops the frame from its FIFO only after a confirmed transmission, or after the retry limit is exhausted. Bus arbitration loss and transmit errors trigger re-scheduling, so a higher-priority frame that arrived meanwhile can pre-empt a pending one.

## Interface
- NUM_FIFOS, 2, number of transmit FIFOs arbitrated (≥2).
- MAX_RETRY, 8, transmit-error attempts per frame before it is dropped (1–255; used only with the retry macro).
- IDX_W, derived `$clog2(NUM_FIFOS)`, width of the FIFO index.

- i_sys_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_fifo_empty  in  NUM_FIFOS  `o_empty` of each FIFO.
- i_fifo_r_data  in  NUM_FIFOS*128  head data of each FIFO; FIFO k occupies bits [128k+127:128k].
- o_fifo_r_en  out  NUM_FIFOS  one-hot pop strobe, one cycle wide.
- o_tx_valid  out  1  frame offered to the transmit engine.
- o_tx_frame  out  128  registered copy of the selected frame.
- i_tx_ready  in  1  engine accepts the frame while `o_tx_valid` is high.
- i_tx_done  in  1  one-cycle pulse: frame transmitted and acknowledged.
- i_tx_arb_lost  in  1  one-cycle pulse: bus arbitration lost.
- i_tx_error  in  1  one-cycle pulse: transmit error.
- o_sel_idx  out  IDX_W  index of the FIFO currently owned.
- o_busy  out  1  high in every state except IDLE.
- o_drop  out  1  one-cycle pulse: the frame was discarded after the retry limit.

## Operation
- Arbitration key: frame bits [127:99], 29 bits, compared as unsigned; lowest key wins.
  - Only non-empty FIFOs compete.
  - On equal keys, the lowest FIFO index wins.
- FSM states: IDLE, SELECT, OFFER, BUSY, POP.
  - **IDLE:** if any `i_fifo_empty` bit is 0, go to SELECT.
  - **SELECT:** compute the winner from the current heads and register `o_sel_idx` and `o_tx_frame`. Go to OFFER. If all FIFOs are now empty, return to IDLE.
  - **OFFER:** hold `o_tx_valid`=1 with `o_tx_frame` stable. When `i_tx_ready`=1, drop valid and go to BUSY.
  - **BUSY:** wait for a result pulse.
    - `i_tx_done`: go to POP and clear the retry count.
    - `i_tx_arb_lost`: go to IDLE. Retry count is unchanged.
    - `i_tx_error`: increment the retry count, then go to IDLE, or to POP with the drop flag set when the limit is reached.
  - **POP:** assert `o_fifo_r_en[o_sel_idx]` for exactly one cycle. Pulse `o_drop` if the drop flag is set. Go to IDLE.
- Simultaneous result pulses are prioritised done > error > arb_lost.
- Result pulses outside BUSY are ignored.
- Retry count (8 bits) belongs to the owning index.
  - Cleared when SELECT picks a different index than the previous owner.
  - Cleared in POP.
- No FIFO is ever popped outside POP. `o_fifo_r_en` is never asserted for an empty FIFO.
- Reset mid-transfer returns to IDLE and clears all state. The head frame stays in its FIFO and is re-offered after reset.

## Timing
- Reset values:
  - FSM=IDLE.
  - `o_tx_valid`, `o_fifo_r_en`, `o_busy`, `o_drop` all 0.
  - `o_tx_frame`=0, `o_sel_idx`=0, retry count 0.
- All outputs are registered, except `o_busy`, which is decoded from state.
- Latency from a FIFO going non-empty (arbiter in IDLE) to `o_tx_valid`=1 is 2 cycles (IDLE→SELECT→OFFER).
- `i_tx_done` to `o_fifo_r_en` pulse: 1 cycle. The FIFO head advances on the following edge.
- The earliest next offer after POP is 2 cycles later (IDLE→SELECT→OFFER). The FIFO flags seen in SELECT already reflect the pop.
- `o_tx_frame` and `o_sel_idx` change only on the SELECT→OFFER transition.

## Configuration
- `CAN_TX_ARB_RETRY_LIMIT_EN` defined:
  - The error retry count is compared against MAX_RETRY.
  - On the MAX_RETRY-th error the frame is popped and `o_drop` pulses.
- Not defined:
  - Errors always return to IDLE and frames are retried indefinitely.
  - `o_drop` is tied to 0, the retry counter is not built, and MAX_RETRY is ignored.

## Test plan
- **Idle bench:** reset, all FIFOs empty for 20 cycles -> `o_tx_valid`, `o_fifo_r_en`, `o_busy` stay 0.
- **Priority:** FIFO0 head key 0x100, FIFO1 head key 0x050 -> `o_sel_idx`=1 and `o_tx_valid` 2 cycles after both are non-empty. After `i_tx_done`, `o_fifo_r_en`=2'b10 for exactly 1 cycle.
- **Tie:** both heads key 0x123 -> FIFO0 served first, then FIFO1.
- **Pre-emption:** FIFO0 key 0x200 in BUSY, FIFO1 loaded with key 0x010, then `i_tx_arb_lost` -> next offer is FIFO1's frame. No pop of FIFO0 occurs.
- **Retry limit (macro on, MAX_RETRY=3):** three `i_tx_error` pulses on the same frame -> third error yields `o_fifo_r_en` plus an `o_drop` pulse. With the macro off, the same stimulus produces 4 offers and no pop.
- **Reset mid-BUSY:** assert `i_reset` for 1 cycle -> all outputs return to reset values. The same frame is re-offered 2 cycles after reset deasserts.

Source files
------------

// File: rtl/can_tx_arbiter.sv
// -----------------------------------------------------------------------------
// can_tx_arbiter
//   Picks the head frame with the lowest 29-bit arbitration key (frame[127:99])
//   among the non-empty transmit FIFOs and offers it to the CAN transmit engine
//   over valid/ready. The owning FIFO is popped only after the engine confirms
//   transmission (or, with the retry limit built in, after the retry budget is
//   spent). Arbitration loss or a transmit error sends the FSM back to IDLE, so
//   every retry re-arbitrates and a newer, higher-priority frame can pre-empt.
//
//   Optional feature macro: CAN_TX_ARB_RETRY_LIMIT_EN
//     defined   : errors are counted per owning FIFO; the MAX_RETRY-th error
//                 pops the frame and pulses o_drop.
//     undefined : errors retry forever, o_drop is tied low, no counter exists.
//
// Ports
//   i_sys_clk, i_reset   clock, synchronous active-high reset
//   i_fifo_empty         per-FIFO empty flags
//   i_fifo_r_data        per-FIFO head frames, FIFO k at [128k+127:128k]
//   o_fifo_r_en          one-hot, one-cycle pop strobe
//   o_tx_valid/o_tx_frame/i_tx_ready   offer handshake to the engine
//   i_tx_done/i_tx_arb_lost/i_tx_error result pulses (honoured in BUSY only)
//   o_sel_idx            FIFO currently owned
//   o_busy               FSM not in IDLE
//   o_drop               frame discarded after the retry limit
// -----------------------------------------------------------------------------
module can_tx_arbiter #(
  parameter int NUM_FIFOS = 2,
  parameter int MAX_RETRY = 8,
  localparam int IDX_W    = $clog2(NUM_FIFOS)
) (
  input  logic                     i_sys_clk,
  input  logic                     i_reset,
  input  logic [NUM_FIFOS-1:0]     i_fifo_empty,
  input  logic [NUM_FIFOS*128-1:0] i_fifo_r_data,
  output logic [NUM_FIFOS-1:0]     o_fifo_r_en,
  output logic                     o_tx_valid,
  output logic [127:0]             o_tx_frame,
  input  logic                     i_tx_ready,
  input  logic                     i_tx_done,
  input  logic                     i_tx_arb_lost,
  input  logic                     i_tx_error,
  output logic [IDX_W-1:0]         o_sel_idx,
  output logic                     o_busy,
  output logic                     o_drop
);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_OFFER, S_BUSY, S_POP
  } state_t;

  state_t state_q, state_d;

  logic [NUM_FIFOS-1:0][127:0] head;
  assign head = i_fifo_r_data;

  // ---------------------------------------------------------------------------
  // Winner search: strict '<' while scanning upward keeps the lowest index on
  // equal keys.
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] win_idx;
  logic             win_vld;
  logic [28:0]      win_key;

  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    win_key = '1;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      if (!i_fifo_empty[i] && (!win_vld || head[i][127:99] < win_key)) begin
        win_vld = 1'b1;
        win_key = head[i][127:99];
        win_idx = IDX_W'(i);
      end
    end
  end

  logic [IDX_W-1:0]     sel_q, sel_d;
  logic [127:0]         frame_q, frame_d;
  logic [NUM_FIFOS-1:0] sel_oh;

  for (genvar g = 0; g < NUM_FIFOS; g++) begin : g_oh
    assign sel_oh[g] = (sel_q == IDX_W'(g));
  end

`ifdef CAN_TX_ARB_RETRY_LIMIT_EN
  logic [7:0] retry_q, retry_d;
  logic       dflag_q, dflag_d;
  logic [8:0] retry_inc;
  assign retry_inc = {1'b0, retry_q} + 9'd1;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    frame_d = frame_q;
`ifdef CAN_TX_ARB_RETRY_LIMIT_EN
    retry_d = retry_q;
    dflag_d = dflag_q;
`endif
    case (state_q)
      S_IDLE: if (~i_fifo_empty != '0) state_d = S_SELECT;
      S_SELECT: begin
        if (win_vld) begin
          state_d = S_OFFER;
          sel_d   = win_idx;
          frame_d = head[win_idx];
`ifdef CAN_TX_ARB_RETRY_LIMIT_EN
          // retry budget belongs to the owner; a new owner starts fresh
          if (win_idx != sel_q) retry_d = '0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_OFFER: if (i_tx_ready) state_d = S_BUSY;
      S_BUSY: begin
        if (i_tx_done) begin
          state_d = S_POP;
`ifdef CAN_TX_ARB_RETRY_LIMIT_EN
          retry_d = '0;
`endif
        end else if (i_tx_error) begin
          state_d = S_IDLE;
`ifdef CAN_TX_ARB_RETRY_LIMIT_EN
          retry_d = retry_inc[7:0];
          if (retry_inc >= 9'(MAX_RETRY)) begin
            state_d = S_POP;
            dflag_d = 1'b1;
          end
`endif
        end else if (i_tx_arb_lost) begin
          state_d = S_IDLE;
        end
      end
      S_POP: begin
        state_d = S_IDLE;
`ifdef CAN_TX_ARB_RETRY_LIMIT_EN
        retry_d = '0;
        dflag_d = 1'b0;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs. Outputs are computed from the next state so
  // they line up with the state they belong to.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      frame_q     <= '0;
      o_tx_valid  <= 1'b0;
      o_fifo_r_en <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      frame_q     <= frame_d;
      o_tx_valid  <= (state_d == S_OFFER);
      // empty mask is belt and braces: the owned FIFO is never popped elsewhere
      o_fifo_r_en <= (state_d == S_POP) ? (sel_oh & ~i_fifo_empty) : '0;
    end
  end

`ifdef CAN_TX_ARB_RETRY_LIMIT_EN
  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      retry_q <= '0;
      dflag_q <= 1'b0;
      o_drop  <= 1'b0;
    end else begin
      retry_q <= retry_d;
      dflag_q <= dflag_d;
      o_drop  <= (state_d == S_POP) && dflag_d;
    end
  end
`else
  assign o_drop = 1'b0;
`endif

  assign o_sel_idx  = sel_q;
  assign o_tx_frame = frame_q;
  assign o_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_can_tx_arbiter.sv
module tb_can_tx_arbiter;

  localparam int NF = 2;

  logic           clk = 1'b0;
  logic           i_reset;
  logic [NF-1:0]  i_fifo_empty;
  logic [NF*128-1:0] i_fifo_r_data;
  logic [NF-1:0]  o_fifo_r_en;
  logic           o_tx_valid;
  logic [127:0]   o_tx_frame;
  logic           i_tx_ready, i_tx_done, i_tx_arb_lost, i_tx_error;
  logic [0:0]     o_sel_idx;
  logic           o_busy, o_drop;

  always #5 clk = ~clk;

  can_tx_arbiter #(.NUM_FIFOS(NF), .MAX_RETRY(3)) dut (
    .i_sys_clk(clk), .i_reset(i_reset),
    .i_fifo_empty(i_fifo_empty), .i_fifo_r_data(i_fifo_r_data),
    .o_fifo_r_en(o_fifo_r_en), .o_tx_valid(o_tx_valid), .o_tx_frame(o_tx_frame),
    .i_tx_ready(i_tx_ready), .i_tx_done(i_tx_done), .i_tx_arb_lost(i_tx_arb_lost),
    .i_tx_error(i_tx_error), .o_sel_idx(o_sel_idx), .o_busy(o_busy), .o_drop(o_drop)
  );

  // ---------------- FIFO model (depth 4, pops on r_en, keeps state on reset)
  logic [127:0] mem [NF][4];
  int           cnt [NF] = '{0, 0};
  int           pop_cnt [NF] = '{0, 0};
  int           spurious = 0;
  logic [NF-1:0] push_vld = '0;
  logic [127:0] push_dat [NF];

  always @(posedge clk) begin
    for (int k = 0; k < NF; k++) begin
      if (o_fifo_r_en[k]) begin
        if (cnt[k] == 0) spurious <= spurious + 1;
        else begin
          for (int j = 0; j < 3; j++) mem[k][j] <= mem[k][j+1];
          pop_cnt[k] <= pop_cnt[k] + 1;
          if (push_vld[k]) mem[k][cnt[k]-1] <= push_dat[k];
          else cnt[k] <= cnt[k] - 1;
        end
      end else if (push_vld[k] && cnt[k] < 4) begin
        mem[k][cnt[k]] <= push_dat[k];
        cnt[k] <= cnt[k] + 1;
      end
    end
  end

  assign i_fifo_empty  = {cnt[1] == 0, cnt[0] == 0};
  assign i_fifo_r_data = {mem[1][0], mem[0][0]};

  // ---------------- checking
  int tests = 0, failed = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mkf(input logic [28:0] key, input int tag);
    return {key, 99'(tag)};
  endfunction

  task automatic push(input logic [1:0] m, input logic [127:0] d0, input logic [127:0] d1);
    push_vld    = m;
    push_dat[0] = d0;
    push_dat[1] = d1;
    @(negedge clk);
    push_vld    = '0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!o_tx_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  // handshake, confirm, and check the single-cycle pop
  task automatic serve_done(input int idx);
    i_tx_ready = 1'b1;
    @(negedge clk);
    i_tx_ready = 1'b0;
    chk("valid_drop_on_ready", o_tx_valid, 0);
    chk("busy_in_busy", o_busy, 1);
    i_tx_done = 1'b1;
    @(negedge clk);
    i_tx_done = 1'b0;
    chk("pop_strobe", o_fifo_r_en, 2'b01 << idx);
    @(negedge clk);
    chk("pop_one_cycle", o_fifo_r_en, 0);
  endtask

  typedef struct {
    logic [1:0]  ld;
    logic [28:0] k0, k1;
    int          first, second;   // second = -1 when only one frame queued
  } arb_vec_t;

  arb_vec_t vecs[6];

  initial begin
    int n, offers, p0;
    logic [127:0] f[2];

    vecs[0] = '{2'b11, 29'h100,      29'h050,      1,  0};
    vecs[1] = '{2'b11, 29'h123,      29'h123,      0,  1};
    vecs[2] = '{2'b10, 29'h0,        29'h0,        1, -1};
    vecs[3] = '{2'b01, 29'h1FFFFFFF, 29'h0,        0, -1};
    vecs[4] = '{2'b11, 29'h1FFFFFFF, 29'h1FFFFFFE, 1,  0};
    vecs[5] = '{2'b11, 29'h0000001,  29'h10000000, 0,  1};

    i_reset = 1'b1; i_tx_ready = 0; i_tx_done = 0; i_tx_arb_lost = 0; i_tx_error = 0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {o_tx_valid, o_fifo_r_en, o_busy, o_drop, o_sel_idx}, 0);
    chk("rst_frame", o_tx_frame, 0);
    i_reset = 1'b0;

    // idle bench
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("idle_quiet", {o_tx_valid, o_fifo_r_en, o_busy}, 0);
    end

    // table-driven arbitration cases
    for (int v = 0; v < 6; v++) begin
      f[0] = mkf(vecs[v].k0, 16 * v + 1);
      f[1] = mkf(vecs[v].k1, 16 * v + 2 + (1 << 90));
      push(vecs[v].ld, f[0], f[1]);
      wait_valid(n);
      chk($sformatf("v%0d_latency", v), n, 2);
      chk($sformatf("v%0d_sel1", v), o_sel_idx, vecs[v].first);
      chk($sformatf("v%0d_frame1", v), o_tx_frame, f[vecs[v].first]);
      serve_done(vecs[v].first);
      if (vecs[v].second >= 0) begin
        wait_valid(n);
        chk($sformatf("v%0d_latency2", v), n, 2);
        chk($sformatf("v%0d_sel2", v), o_sel_idx, vecs[v].second);
        chk($sformatf("v%0d_frame2", v), o_tx_frame, f[vecs[v].second]);
        serve_done(vecs[v].second);
      end
      @(negedge clk);
      chk($sformatf("v%0d_drained", v), {o_busy, i_fifo_empty}, 3'b011);
    end

    // pre-emption after arbitration loss; result pulses in OFFER are ignored
    f[0] = mkf(29'h200, 7);
    f[1] = mkf(29'h010, 9);
    p0 = pop_cnt[0];
    push(2'b01, f[0], '0);
    wait_valid(n);
    i_tx_done = 1'b1;
    @(negedge clk);
    i_tx_done = 1'b0;
    chk("offer_ignores_done", {o_tx_valid, o_fifo_r_en}, 3'b100);
    i_tx_ready = 1'b1;
    @(negedge clk);
    i_tx_ready = 1'b0;
    push(2'b10, '0, f[1]);
    i_tx_arb_lost = 1'b1;
    @(negedge clk);
    i_tx_arb_lost = 1'b0;
    chk("arb_lost_idle", {o_busy, o_fifo_r_en}, 0);
    wait_valid(n);
    chk("preempt_latency", n, 2);
    chk("preempt_sel", o_sel_idx, 1);
    chk("preempt_frame", o_tx_frame, f[1]);
    chk("no_pop_fifo0", pop_cnt[0], p0);
    serve_done(1);
    wait_valid(n);
    chk("reoffer_fifo0", o_tx_frame, f[0]);
    serve_done(0);

    // retry behaviour on transmit errors
    f[0] = mkf(29'h0AA, 11);
    p0 = pop_cnt[0];
    offers = 0;
    push(2'b01, f[0], '0);
    for (int a = 0; a < 3; a++) begin
      wait_valid(n);
      if (o_tx_valid) offers++;
      i_tx_ready = 1'b1;
      @(negedge clk);
      i_tx_ready = 1'b0;
      i_tx_error = 1'b1;
      @(negedge clk);
      i_tx_error = 1'b0;
`ifdef CAN_TX_ARB_RETRY_LIMIT_EN
      if (a < 2) chk("err_no_pop", {o_fifo_r_en, o_drop}, 0);
      else begin
        chk("limit_pop_drop", {o_fifo_r_en, o_drop}, 3'b011);
        @(negedge clk);
        chk("drop_one_cycle", {o_fifo_r_en, o_drop}, 0);
        chk("dropped_popped", pop_cnt[0], p0 + 1);
      end
`else
      chk("err_no_pop", {o_fifo_r_en, o_drop}, 0);
`endif
    end
`ifndef CAN_TX_ARB_RETRY_LIMIT_EN
    wait_valid(n);
    if (o_tx_valid) offers++;
    chk("retry_offers", offers, 4);
    chk("retry_no_pop", pop_cnt[0], p0);
    serve_done(0);
`endif

    // reset while BUSY: frame stays queued and comes back
    f[1] = mkf(29'h077, 13);
    push(2'b10, '0, f[1]);
    wait_valid(n);
    i_tx_ready = 1'b1;
    @(negedge clk);
    i_tx_ready = 1'b0;
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    chk("midrst_outputs", {o_tx_valid, o_fifo_r_en, o_busy, o_drop, o_sel_idx}, 0);
    chk("midrst_frame", o_tx_frame, 0);
    wait_valid(n);
    chk("post_rst_latency", n, 2);
    chk("post_rst_sel", o_sel_idx, 1);
    chk("post_rst_frame", o_tx_frame, f[1]);
    serve_done(1);

    @(negedge clk);
    chk("no_empty_pops", spurious, 0);
    chk("all_drained", i_fifo_empty, 2'b11);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
